// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline latch for the instruction fetch stage.
//
// Instruction fetch is driven by the load-use stall controls from the hazard
// detect unit. A taken branch or jump resolved in EX redirects the PC and
// squashes the IF/ID latch. The block also keeps a saturating count of stall
// cycles for performance monitoring.
//
// Ports:
//   clk            in   rising-edge system clock
//   rst_n          in   synchronous active-low reset
//   PCLocker       in   1 = PC may advance, 0 = PC holds
//   IF_IDLocker    in   1 = IF/ID may load, 0 = IF/ID holds
//   redirectValid  in   taken branch/jump resolved in EX
//   redirectTarget in   redirect destination PC (low two bits ignored)
//   imemAddr       out  instruction-memory address (combinational from PC)
//   imemData       in   instruction word for imemAddr, valid in the same cycle
//   ifIdPC         out  PC of the instruction held in IF/ID
//   ifIdInst       out  instruction held in IF/ID
//   ifIdValid      out  IF/ID holds a real instruction
//   stallActive    out  fetch FSM is in STALL
//   stallCount     out  saturating stall-cycle counter
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     INST_NOP = 32'h0000_0013,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCLocker,
    input  logic             IF_IDLocker,
    input  logic             redirectValid,
    input  logic [XLEN-1:0]  redirectTarget,
    output logic [XLEN-1:0]  imemAddr,
    input  logic [31:0]      imemData,
    output logic [XLEN-1:0]  ifIdPC,
    output logic [31:0]      ifIdInst,
    output logic             ifIdValid,
    output logic             stallActive,
    output logic [CNT_W-1:0] stallCount
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  if_id_pc_q, if_id_pc_d;
    logic [31:0]      if_id_inst_q, if_id_inst_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // A stall cycle: IF/ID is frozen and no redirect is flushing it.
    logic             hold;
    logic [XLEN-1:0]  redirect_pc;

    assign hold        = !IF_IDLocker && !redirectValid;
    // Force word alignment by masking the two low bits of the target.
    assign redirect_pc = redirectTarget & ~XLEN'(3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= INST_NOP;
            if_id_valid_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        stall_count_d = stall_count_q;

        case (state_q)
            BOOT: begin
                // First cycle after reset: lockers and redirect are ignored,
                // PC stays at RESET_PC and a bubble is placed in IF/ID.
                if_id_pc_d    = pc_q;
                if_id_inst_d  = INST_NOP;
                if_id_valid_d = 1'b0;
                state_d       = RUN;
            end

            default: begin
                // RUN and STALL share the datapath rules; they differ only in
                // how stallActive is reported.
                state_d = hold ? STALL : RUN;

                if (redirectValid) begin
                    pc_d = redirect_pc;
                end else if (PCLocker) begin
                    pc_d = pc_q + XLEN'(4);
                end

                if (redirectValid) begin
                    if_id_pc_d    = pc_q;
                    if_id_inst_d  = INST_NOP;
                    if_id_valid_d = 1'b0;
                end else if (IF_IDLocker) begin
                    if_id_pc_d    = pc_q;
                    if_id_inst_d  = imemData;
                    if_id_valid_d = 1'b1;
                end

                if (hold && (stall_count_q != '1)) begin
                    stall_count_d = stall_count_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign imemAddr    = pc_q;
    assign ifIdPC      = if_id_pc_q;
    assign ifIdInst    = if_id_inst_q;
    assign ifIdValid   = if_id_valid_q;
    assign stallActive = (state_q == STALL);
    assign stallCount  = stall_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage.
//
// A driver applies directed and random inputs on the falling edge, advances a
// behavioural model of the fetch stage by one cycle and pushes the expected
// post-edge outputs into a queue. A monitor samples the DUT after each rising
// edge, pops the queue and compares. The stall counter is built 4 bits wide
// so saturation is reachable.
module tb_fetch_stage;

    localparam int          XLEN     = 32;
    localparam int          CNT_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pc_locker;
    logic             if_id_locker;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_target;
    logic [XLEN-1:0]  imem_addr;
    logic [31:0]      imem_data;
    logic [XLEN-1:0]  if_id_pc;
    logic [31:0]      if_id_inst;
    logic             if_id_valid;
    logic             stall_active;
    logic [CNT_W-1:0] stall_count;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .INST_NOP (INST_NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PCLocker       (pc_locker),
        .IF_IDLocker    (if_id_locker),
        .redirectValid  (redirect_valid),
        .redirectTarget (redirect_target),
        .imemAddr       (imem_addr),
        .imemData       (imem_data),
        .ifIdPC         (if_id_pc),
        .ifIdInst       (if_id_inst),
        .ifIdValid      (if_id_valid),
        .stallActive    (stall_active),
        .stallCount     (stall_count)
    );

    // Address-indexed instruction ROM: word index in the low half, a
    // scrambled copy in the high half so neighbouring words differ.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[17:2] ^ 16'h5A3C, a[17:2]};
    endfunction

    assign imem_data = rom(imem_addr);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ifpc;
        logic [31:0] inst;
        logic        valid;
        logic        sact;
        int unsigned cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] m_inst;
    logic        m_valid;
    int unsigned m_cnt;
    bit          m_first_after_reset;
    bit          m_stalled;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one comparison set per rising edge that has an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("imemAddr",    imem_addr,           e.addr);
                chk("ifIdPC",      if_id_pc,            e.ifpc);
                chk("ifIdInst",    if_id_inst,          e.inst);
                chk("ifIdValid",   32'(if_id_valid),    32'(e.valid));
                chk("stallActive", 32'(stall_active),   32'(e.sact));
                chk("stallCount",  32'(stall_count),    32'(e.cnt));
            end
        end
    end

    // One clock of stimulus: drive inputs, advance the model, queue expectation.
    task automatic step(input bit r, input bit pcl, input bit ifl,
                        input bit rv, input logic [31:0] tgt);
        exp_t        e;
        logic [31:0] cur_pc;
        @(negedge clk);
        rst_n           = r;
        pc_locker       = pcl;
        if_id_locker    = ifl;
        redirect_valid  = rv;
        redirect_target = tgt;
        cur_pc          = m_pc;

        if (!r) begin
            m_pc                = RESET_PC;
            m_ifpc              = 32'h0;
            m_inst              = INST_NOP;
            m_valid             = 1'b0;
            m_cnt               = 0;
            m_first_after_reset = 1'b1;
            m_stalled           = 1'b0;
        end else if (m_first_after_reset) begin
            m_ifpc              = cur_pc;
            m_inst              = INST_NOP;
            m_valid             = 1'b0;
            m_first_after_reset = 1'b0;
            m_stalled           = 1'b0;
        end else begin
            if (rv) begin
                m_pc    = {tgt[31:2], 2'b00};
                m_ifpc  = cur_pc;
                m_inst  = INST_NOP;
                m_valid = 1'b0;
            end else begin
                if (pcl) m_pc = cur_pc + 32'd4;
                if (ifl) begin
                    m_ifpc  = cur_pc;
                    m_inst  = rom(cur_pc);
                    m_valid = 1'b1;
                end
            end
            m_stalled = !ifl && !rv;
            if (m_stalled && m_cnt < 15) m_cnt = m_cnt + 1;
        end

        e.addr  = m_pc;
        e.ifpc  = m_ifpc;
        e.inst  = m_inst;
        e.valid = m_valid;
        e.sact  = m_stalled;
        e.cnt   = m_cnt;
        sb.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; pc_locker = 1'b0; if_id_locker = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
        m_pc = RESET_PC; m_ifpc = '0; m_inst = INST_NOP; m_valid = 1'b0;
        m_cnt = 0; m_first_after_reset = 1'b1; m_stalled = 1'b0;

        // Reset and boot, then run up to PC=0x10.
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
        // Single-cycle load-use stall at PC=0x10, then resume.
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        // Redirect arriving during a stall, unaligned target.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h0000_0103);
        step(1, 1, 1, 0, 0);
        // PC wrap past the top of the address space.
        step(1, 1, 1, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        // Mismatched lockers: PC frozen, IF/ID keeps recapturing.
        step(1, 1, 1, 1, 32'h0000_0020);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
        // Long stall to saturate the counter, then reset mid-stall with a
        // redirect pending; the boot cycle must ignore the redirect.
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0400);
        step(1, 0, 0, 1, 32'h0000_0400);
        step(1, 1, 1, 0, 0);
        // Dropped-word combination must not hang.
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);

        // Random phase.
        for (int i = 0; i < 400; i++) begin
            bit r, pcl, ifl, rv;
            int unsigned sel;
            r   = ($urandom_range(0, 99) >= 2);
            rv  = ($urandom_range(0, 99) < 15);
            sel = $urandom_range(0, 9);
            if (sel < 6)      begin pcl = 1; ifl = 1; end
            else if (sel < 8) begin pcl = 0; ifl = 0; end
            else if (sel < 9) begin pcl = 0; ifl = 1; end
            else              begin pcl = 1; ifl = 0; end
            step(r, pcl, ifl, rv, $urandom());
        end

        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
PC register and IF/ID pipeline latch that consume the load-use stall controls `PCLocker` and `IF_IDLocker` from the hazard detect unit. Drives the instruction-memory address, captures the fetched instruction into IF/ID, and squashes IF/ID on a branch/jump redirect from EX. Also counts stall cycles for performance monitoring.

Parameters:
XLEN, 32, PC and data width
RESET_PC, 32'h0000_0000, PC value loaded on reset
INST_NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)
CNT_W, 16, stall counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, synchronous, active-low
PCLocker  input  1  1 = PC may advance, 0 = PC holds
IF_IDLocker  input  1  1 = IF/ID may load, 0 = IF/ID holds
redirectValid  input  1  taken branch/jump resolved in EX
redirectTarget  input  XLEN  redirect destination PC
imemAddr  output  XLEN  instruction-memory address (combinational from PC)
imemData  input  32  instruction word for imemAddr, valid in same cycle
ifIdPC  output  XLEN  PC of instruction in IF/ID
ifIdInst  output  32  instruction in IF/ID
ifIdValid  output  1  IF/ID holds a real instruction
stallActive  output  1  FSM in STALL
stallCount  output  CNT_W  saturating stall-cycle counter

Behaviour:
- Synchronous active-low reset on the clk edge with rst_n=0: PC=RESET_PC, ifIdPC=0, ifIdInst=INST_NOP, ifIdValid=0, stallCount=0, state=BOOT, stallActive=0. Reset applied mid-stall or mid-redirect overrides everything.
- imemAddr = PC, combinational. Fetch-to-IF/ID latency is 1 cycle.
- FSM states: BOOT, RUN, STALL.
  - BOOT: lasts exactly 1 cycle after reset release. PC holds RESET_PC. IF/ID loads a bubble (INST_NOP, valid=0). Lockers and redirect are ignored. Next state is RUN.
  - RUN -> STALL when IF_IDLocker=0 and redirectValid=0.
  - STALL -> RUN when IF_IDLocker=1 or redirectValid=1.
  - RUN stays RUN otherwise.
- PC update (RUN/STALL), priority order:
  1. redirectValid=1: PC <= {redirectTarget[XLEN-1:2],2'b00}. Redirect overrides PCLocker=0.
  2. else PCLocker=1: PC <= PC+4, modulo 2^XLEN; 0xFFFF_FFFC wraps to 0.
  3. else PC holds.
- IF/ID update (RUN/STALL), priority order:
  1. redirectValid=1: ifIdInst<=INST_NOP, ifIdValid<=0, ifIdPC<=PC (flush). Overrides IF_IDLocker=0.
  2. else IF_IDLocker=1: ifIdPC<=PC, ifIdInst<=imemData, ifIdValid<=1.
  3. else all three hold their values.
- The two lockers act independently. PCLocker=0 with IF_IDLocker=1 recaptures the same PC/instruction, which is legal. PCLocker=1 with IF_IDLocker=0 drops the fetched word; the hazard unit never drives this combination, but the block must not hang if it occurs.
- stallCount increments by 1 on each cycle in RUN or STALL where IF_IDLocker=0 and redirectValid=0. It saturates at 2^CNT_W-1 and does not wrap. It clears only on reset.
- stallActive = (state==STALL), registered.
- A multi-cycle stall holds PC, IF/ID and imemAddr stable for every cycle of the stall.

Test Plan:
- Reset/boot: rst_n=0 for 2 cycles, then 1; imemData=addr-indexed ROM -> cycle 1 after release: ifIdValid=0, PC=0; cycle 2: ifIdPC=0, ifIdValid=1; cycle 3: ifIdPC=4, ifIdInst=ROM[1].
- Load-use stall: both lockers=0 for 1 cycle while PC=0x10 -> PC stays 0x10, IF/ID keeps 0x0C, stallActive=1 for 1 cycle, stallCount=1; next cycle IF/ID=0x10.
- Redirect during stall: lockers=0 with redirectValid=1, target=0x103 -> PC=0x100, ifIdValid=0, ifIdInst=0x13, state RUN, stallCount unchanged.
- Wrap: redirect to 0xFFFF_FFFC, then lockers=1 -> PC sequence 0xFFFF_FFFC, 0x0, 0x4.
- Saturation with CNT_W=4: IF_IDLocker=0 for 20 cycles -> stallCount stops at 15; reset mid-stall -> stallCount=0, ifIdValid=0, state BOOT.
- Mismatched lockers: PCLocker=0, IF_IDLocker=1 for 3 cycles at PC=0x20 -> ifIdPC=0x20 each cycle, ifIdValid=1, stallCount unchanged.
